// File: rtl/mult_pipeline_if.sv
// Issue/result handshake bundle for the pipelined multiply unit.
// master = producer/consumer side, slave = the multiply unit.
interface mult_pipeline_if #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [1:0]       in_func;
   logic [XLEN-1:0]  in_opa;
   logic [XLEN-1:0]  in_opb;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [XLEN-1:0]  out_result;
   logic [TAG_W-1:0] out_tag;

   modport master (
      output in_valid, in_func, in_opa, in_opb, in_tag, out_ready,
      input  in_ready, out_valid, out_result, out_tag
   );

   modport slave (
      input  in_valid, in_func, in_opa, in_opb, in_tag, out_ready,
      output in_ready, out_valid, out_result, out_tag
   );
endinterface

// File: rtl/mult_pipeline.sv
// Fully pipelined RV32M MUL/MULH/MULHSU/MULHU unit: one op per cycle, results in
// issue order after STAGES cycles, global stall on output backpressure, 1-cycle flush.
module mult_pipeline #(
   parameter int XLEN   = 32,
   parameter int STAGES = 4,
   parameter int TAG_W  = 8
) (
   input  logic           clock,
   input  logic           reset,
   input  logic           flush,
   mult_pipeline_if.slave bus
);
   localparam int W = 2 * XLEN;
   localparam int C = W / STAGES;

   typedef enum logic [1:0] {
      FN_MUL    = 2'b00,
      FN_MULH   = 2'b01,
      FN_MULHSU = 2'b10,
      FN_MULHU  = 2'b11
   } func_e;

   // Slot k holds the operands plus the sum of chunks 0..k-1; the output
   // register adds the final chunk, so latency is exactly STAGES edges.
   typedef struct packed {
      func_e            func;
      logic [W-1:0]     opa;
      logic [W-1:0]     opb;
      logic [W-1:0]     acc;
      logic [TAG_W-1:0] tag;
   } slot_t;

   slot_t             slot_q [STAGES];
   slot_t             slot_d [STAGES];
   logic [STAGES-1:0] vld_q, vld_d;
   logic              out_valid_q, out_valid_d;
   logic [XLEN-1:0]   out_result_q, out_result_d;
   logic [TAG_W-1:0]  out_tag_q, out_tag_d;

   func_e        in_func_e;
   logic         sign_a, sign_b;
   logic         stall, accept;
   logic [W-1:0] final_acc;

   function automatic logic [W-1:0] add_chunk(input slot_t s, input int k);
      logic [W-1:0] chunk;
      chunk = W'(s.opb[k*C +: C]);
      return s.acc + ((s.opa * chunk) << (k * C));
   endfunction

   assign in_func_e = func_e'(bus.in_func);
   assign sign_a    = (in_func_e != FN_MULHU) && bus.in_opa[XLEN-1];
   assign sign_b    = ((in_func_e == FN_MUL) || (in_func_e == FN_MULH)) && bus.in_opb[XLEN-1];

   assign stall        = out_valid_q && !bus.out_ready;
   assign accept       = bus.in_valid && !stall && !flush;
   assign bus.in_ready = !stall;

   always_comb begin
      // NOTE: every variable gets a default first so no path infers a latch.
      slot_d       = slot_q;
      vld_d        = vld_q;
      out_valid_d  = out_valid_q;
      out_result_d = out_result_q;
      out_tag_d    = out_tag_q;
      final_acc    = add_chunk(slot_q[STAGES-1], STAGES - 1);

      if (!stall) begin
         vld_d[0] = accept;
         if (accept) begin
            slot_d[0].func = in_func_e;
            slot_d[0].opa  = {{XLEN{sign_a}}, bus.in_opa};
            slot_d[0].opb  = {{XLEN{sign_b}}, bus.in_opb};
            slot_d[0].acc  = '0;
            slot_d[0].tag  = bus.in_tag;
         end
         for (int k = 1; k < STAGES; k++) begin
            vld_d[k] = vld_q[k-1];
            if (vld_q[k-1]) begin
               slot_d[k]     = slot_q[k-1];
               slot_d[k].acc = add_chunk(slot_q[k-1], k - 1);
            end
         end
         out_valid_d = vld_q[STAGES-1];
         // Output data only moves on a real result, so it holds across bubbles.
         if (vld_q[STAGES-1] && !flush) begin
            out_result_d = (slot_q[STAGES-1].func == FN_MUL) ? final_acc[XLEN-1:0]
                                                             : final_acc[W-1:XLEN];
            out_tag_d    = slot_q[STAGES-1].tag;
         end
      end

      if (flush) begin
         vld_d       = '0;
         out_valid_d = 1'b0;
      end
   end

   // NOTE: non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clock) begin
      if (reset) begin
         vld_q        <= '0;
         out_valid_q  <= 1'b0;
         out_result_q <= '0;
         out_tag_q    <= '0;
      end else begin
         vld_q        <= vld_d;
         out_valid_q  <= out_valid_d;
         out_result_q <= out_result_d;
         out_tag_q    <= out_tag_d;
      end
   end

   // NOTE: datapath slots carry no reset; the valid bits alone decide what is live.
   always_ff @(posedge clock) begin
      slot_q <= slot_d;
   end

   assign bus.out_valid  = out_valid_q;
   assign bus.out_result = out_result_q;
   assign bus.out_tag    = out_tag_q;
endmodule

// File: doc/mult_pipeline.md
# mult_pipeline

Parametrised, fully pipelined integer multiply unit for the execute stage, implementing RV32M MUL/MULH/MULHSU/MULHU. It accepts one operation per cycle over a valid/ready handshake and carries an opaque tag (ROB/RS index, destination tag) alongside each operation. Results emerge in issue order after exactly `STAGES` cycles, with global backpressure and a single-cycle flush for mispredict recovery. It replaces the single-shot start/done multiplier wrapper in the FU bank.

## Interface
- `XLEN`, 32, operand and result width.
- `STAGES`, 4, pipeline depth in cycles; must divide `2*XLEN` (legal: 1, 2, 4, 8, 16, 32, 64 for XLEN=32).
- `TAG_W`, 8, width of the pass-through tag.
- `clock`  in  1  clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-high.
- `in_valid`  in  1  an operation is offered.
- `in_ready`  out  1  unit accepts the offered operation this cycle.
- `in_func`  in  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU (funct3[1:0]).
- `in_opa`  in  XLEN  multiplicand (rs1).
- `in_opb`  in  XLEN  multiplier (rs2).
- `in_tag`  in  TAG_W  opaque tag, returned unchanged.
- `flush`  in  1  squash every in-flight operation.
- `out_valid`  out  1  `out_result`/`out_tag` are valid.
- `out_ready`  in  1  consumer takes the result this cycle.
- `out_result`  out  XLEN  selected product half.
- `out_tag`  out  TAG_W  tag of the result.

## Operation
- Accept when `in_valid && in_ready && !flush`.
- Operand extension to 2·XLEN at accept: opa sign-extended for MUL/MULH/MULHSU, else zero; opb sign-extended for MUL/MULH, else zero.
- Chunk width `C = 2*XLEN/STAGES`. Stage k (0..STAGES-1) adds `ext_opa * ext_opb[k*C +: C]`, shifted left by `k*C`, into a 2·XLEN accumulator, truncated mod 2^(2·XLEN). Operands, func, tag and partial sum travel with a per-stage valid bit.
- Output select on the final accumulator: MUL → bits [XLEN-1:0]; MULH/MULHSU/MULHU → bits [2XLEN-1:XLEN].
- `out_*` is registered as the last pipeline stage; `out_result`/`out_tag` are undefined-free: they hold their last value when `out_valid`=0.
- Stall: `stall = out_valid && !out_ready`. While stalled, every stage holds its contents, including bubbles; `in_ready = !stall` (combinational, no dependence on `in_valid`).
- Flush: on a cycle with `flush`=1, all stage valid bits and `out_valid` clear at that edge; any input presented that cycle is dropped. Flush overrides stall. Data registers need not clear.
- Ordering: strictly FIFO; no reordering, no duplication, no loss under any mix of stall and bubbles.

## Timing
- Reset: `out_valid`=0, `out_result`=0, `out_tag`=0, all stage valids 0; `in_ready`=1 in the first cycle after reset (since `out_valid`=0).
- Latency: op accepted at edge N presents `out_valid`=1 after edge N+STAGES when no stall occurs; each stalled cycle adds one.
- Throughput: one op per cycle when `out_ready`=1 continuously.
- Result handshake completes at the edge where `out_valid && out_ready`; the next op (if any in the last internal slot) appears the cycle after.
- Reset mid-operation discards everything in flight; no result from before reset ever appears.
- Simultaneous `flush` and `out_valid && out_ready`: the presented result counts as consumed; nothing else survives.
- Simultaneous `reset` and `flush`: reset behaviour.

## Test plan
- XLEN=32, STAGES=4: MUL 7×6, tag 0x11, accept at edge 0 → `out_valid` after edge 4, `out_result`=0x0000002A, `out_tag`=0x11.
- Signedness, opa=opb=0xFFFFFFFF: MUL → 0x00000001; MULH → 0x00000000; MULHU → 0xFFFFFFFE; MULHSU → 0xFFFFFFFF. Also MULH 0x80000000×0x80000000 → 0x40000000.
- Streaming: 8 back-to-back ops, tags 0..7, `out_ready`=1 → results on 8 consecutive cycles starting after edge 4, tags in order 0..7, `in_ready` never low.
- Backpressure: stream 6 ops, drop `out_ready` for 3 cycles while `out_valid`=1 → `in_ready`=0 for exactly those cycles, `out_result`/`out_tag` stable, all 6 results delivered in order, none lost or duplicated.
- Flush: issue tags 1..3 on consecutive cycles, assert `flush` one cycle after tag 3 with tag 4 offered → `out_valid` never asserts for 1..4; tag 5 issued next cycle appears 4 cycles later.
- Reset mid-flight: 3 ops in pipe, pulse `reset` 1 cycle → outputs return to reset values, no stale result ever appears, a new MULHU 0x00010000×0x00010000 yields 0x00000001.
